layer_ctrl: RTL and testbench
=============================

Name: layer_ctrl

Overview:
Frame-synchronous controller for the pixel layer compositor. It drives the menu-overlay select and the per-layer enables that gate the layer request flags. It commits every visual change only at frame boundaries (vblank) to avoid tearing. It also blinks layer 3 (win banner) and rate-limits menu toggles. It sits between game_core/keyboard logic and the layer priority mux.

Parameters:
BLINK_FRAMES, 30, frames per blink half-period for layer 3 while win_flag=1 (>=1)
TOGGLE_GUARD, 8, minimum frames between two committed menu toggles (>=1)
MASK_RST, 4'b0111, reset value of active and shadow layer masks (layers 0..2 on, 3 off)

Ports:
clk  input  1  pixel/system clock
rst_n  input  1  asynchronous active-low reset
frame_start  input  1  one-cycle pulse at start of vblank
menu_req  input  1  level request to toggle menu; held until menu_ack
menu_ack  output  1  one-cycle pulse when a toggle is committed
mask_wr  input  1  one-cycle strobe: capture layer_mask_in
layer_mask_in  input  4  requested enables, bit i = layer i
win_flag  input  1  level from game core; enables blinking of layer 3
switch_sel  output  1  menu overlay select to compositor
layer_en  output  4  per-layer enables (ANDed with RqFlag0..3 downstream)
blink_on  output  1  current blink phase
busy  output  1  toggle pending (PEND states) or guard counter nonzero

Behaviour:
- Reset (async, rst_n=0): state=HIDDEN, switch_sel=0, menu_ack=0, shadow=active=MASK_RST, layer_en=MASK_RST, guard=0, blink_cnt=0, blink_on=1, busy=0. Reset mid-pending drops the request without an ack.
- All outputs are registered. Changes driven by frame_start are visible on the cycle after frame_start.
- Menu FSM, states HIDDEN, OPEN_PEND, SHOWN, CLOSE_PEND:
  - HIDDEN & menu_req & guard==0 -> OPEN_PEND.
  - OPEN_PEND & frame_start -> SHOWN, switch_sel<=1, menu_ack<=1 for 1 cycle, guard<=TOGGLE_GUARD.
  - SHOWN & menu_req & guard==0 -> CLOSE_PEND.
  - CLOSE_PEND & frame_start -> HIDDEN, switch_sel<=0, menu_ack pulse, guard<=TOGGLE_GUARD.
  - menu_req while guard!=0: no transition and no ack. The requester keeps holding.
  - menu_req sampled in the same cycle as frame_start while in HIDDEN/SHOWN: enter PEND only. The commit waits for the next frame_start (at least one full frame of latency).
  - Deassertion of menu_req in a PEND state does not cancel the commit.
  - After an ack, menu_req must drop before the next toggle. The FSM requires a low cycle of menu_req (edge-armed flag) before leaving HIDDEN/SHOWN again.
- Guard: on each frame_start, if guard!=0 then guard-1, except when a commit in the same cycle reloads it (reload wins). Width is clog2(TOGGLE_GUARD+1).
- Layer mask:
  - mask_wr: shadow<=layer_mask_in.
  - frame_start: active<=shadow.
  - mask_wr and frame_start in the same cycle: active takes the old shadow, shadow takes the new value, so the new mask applies at the following frame_start.
- layer_en[2:0]=active[2:0].
- layer_en[3]=active[3] & (win_flag ? blink_on : 1).
- Blink:
  - While win_flag=0: blink_cnt=0, blink_on=1.
  - While win_flag=1: blink_cnt increments on each frame_start. When it reaches BLINK_FRAMES-1, it wraps to 0 and blink_on toggles.
  - A win_flag falling edge restores blink_on=1 next cycle.
- busy=(state is OPEN_PEND or CLOSE_PEND) | (guard!=0).

Decomposition:
- Shared package layer_pkg: menu state encoding (2-bit, HIDDEN=0, OPEN_PEND=1, SHOWN=2, CLOSE_PEND=3), NUM_LAYERS=4, layer index constants (LAYER_BG=0 … LAYER_BANNER=3).
- One natural sub-module: frame_div, a frame-pulse-driven modulo counter with toggle output. It is instantiated for blink, and its pattern is reused for the guard down-counter.

Test Plan:
- Reset: rst_n=0 mid-frame -> switch_sel=0, layer_en=4'b0111, blink_on=1, busy=0 immediately (async).
- Open menu: menu_req=1 at cycle 10, frame_start at cycle 100 -> switch_sel 0->1 and menu_ack=1 at cycle 101 only, busy=1 from cycle 11.
- Guard: close requested right after open with TOGGLE_GUARD=8 -> no ack through 8 frame_starts. Commit occurs at the 9th frame_start (guard 0 then PEND then commit next frame), switch_sel=0.
- Mask race: mask_wr with layer_mask_in=4'b1111 in the same cycle as frame_start -> layer_en stays 4'b0111. It becomes 4'b1111 (win_flag=0) after the next frame_start.
- Blink: active[3]=1, win_flag=1, BLINK_FRAMES=2 -> layer_en[3] toggles every 2 frame_starts (1,1,0,0,1…). Dropping win_flag forces layer_en[3]=1 next cycle.
- Reset while OPEN_PEND: rst_n pulse before frame_start -> no menu_ack, switch_sel remains 0 after release.

Source files
------------

// File: rtl/layer_pkg.sv
// Shared types and constants for the layer compositor controller.
// Menu FSM encoding, layer count and layer index names.
package layer_pkg;

  typedef enum logic [1:0] {
    HIDDEN     = 2'd0,
    OPEN_PEND  = 2'd1,
    SHOWN      = 2'd2,
    CLOSE_PEND = 2'd3
  } menu_state_e;

  localparam int NUM_LAYERS   = 4;
  localparam int LAYER_BG     = 0;
  localparam int LAYER_TILE   = 1;
  localparam int LAYER_SPRITE = 2;
  localparam int LAYER_BANNER = 3;

  function automatic logic is_pend(menu_state_e s);
    return (s == OPEN_PEND) || (s == CLOSE_PEND);
  endfunction

endpackage

// File: rtl/frame_div.sv
// Frame-pulse modulo-DIV counter whose output toggles on every wrap; sync clear forces count 0, toggle 1.
// Registered toggle plus its next value, so a parent can register logic on the same update; never stalls.
module frame_div #(
  parameter int DIV = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_tick,
  output logic o_tgl,
  output logic o_tgl_nxt
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_tgl;
  logic          w_tgl_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_tgl_nxt = r_tgl;
    if (i_clr) begin
      w_cnt_nxt = '0;
      w_tgl_nxt = 1'b1;
    end else if (i_tick) begin
      if (r_cnt == CW'(DIV - 1)) begin
        w_cnt_nxt = '0;
        w_tgl_nxt = ~r_tgl;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_tgl <= 1'b1;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_tgl <= w_tgl_nxt;
    end
  end

  assign o_tgl     = r_tgl;
  assign o_tgl_nxt = w_tgl_nxt;

endmodule

// File: rtl/layer_ctrl.sv
// Frame-synchronous menu select, layer enables and banner blink; all changes commit on frame_start.
// Outputs registered, visible the cycle after frame_start; menu_req is held by the requester until menu_ack.
module layer_ctrl
  import layer_pkg::*;
#(
  parameter int                    BLINK_FRAMES = 30,
  parameter int                    TOGGLE_GUARD = 8,
  parameter logic [NUM_LAYERS-1:0] MASK_RST     = 4'b0111
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  menu_req,
  output logic                  menu_ack,
  input  logic                  mask_wr,
  input  logic [NUM_LAYERS-1:0] layer_mask_in,
  input  logic                  win_flag,
  output logic                  switch_sel,
  output logic [NUM_LAYERS-1:0] layer_en,
  output logic                  blink_on,
  output logic                  busy
);

  localparam int GW = $clog2(TOGGLE_GUARD + 1);

  menu_state_e           r_state;
  menu_state_e           w_state_nxt;
  logic                  w_commit;
  logic                  w_guard_zero;
  logic [GW-1:0]         r_guard;
  logic [GW-1:0]         w_guard_nxt;
  logic                  r_armed;
  logic                  r_sel;
  logic                  r_ack;
  logic                  r_busy;
  logic [NUM_LAYERS-1:0] r_shadow;
  logic [NUM_LAYERS-1:0] r_active;
  logic [NUM_LAYERS-1:0] w_active_nxt;
  logic [NUM_LAYERS-1:0] r_layer_en;
  logic                  w_blink;
  logic                  w_blink_nxt;

  assign w_guard_zero = (r_guard == '0);
  assign w_active_nxt = frame_start ? r_shadow : r_active;

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      HIDDEN:     if (menu_req && r_armed && w_guard_zero) w_state_nxt = OPEN_PEND;
      OPEN_PEND:  if (frame_start) begin
                    w_state_nxt = SHOWN;
                    w_commit    = 1'b1;
                  end
      SHOWN:      if (menu_req && r_armed && w_guard_zero) w_state_nxt = CLOSE_PEND;
      CLOSE_PEND: if (frame_start) begin
                    w_state_nxt = HIDDEN;
                    w_commit    = 1'b1;
                  end
      default:    w_state_nxt = HIDDEN;
    endcase
  end

  // A commit reloads the guard even on the frame that would otherwise count it down.
  always_comb begin
    w_guard_nxt = r_guard;
    if (w_commit) begin
      w_guard_nxt = GW'(TOGGLE_GUARD);
    end else if (frame_start && !w_guard_zero) begin
      w_guard_nxt = r_guard - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= HIDDEN;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed    <= 1'b1;
      r_sel      <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_guard    <= '0;
      r_shadow   <= MASK_RST;
      r_active   <= MASK_RST;
      r_layer_en <= MASK_RST;
    end else begin
      r_ack   <= w_commit;
      r_guard <= w_guard_nxt;
      r_busy  <= is_pend(w_state_nxt) || (w_guard_nxt != '0);
      if (w_commit) r_sel <= (w_state_nxt == SHOWN);
      // Re-armed only by a low cycle of menu_req, so a held request toggles once.
      if (!menu_req) begin
        r_armed <= 1'b1;
      end else if (is_pend(w_state_nxt) && !is_pend(r_state)) begin
        r_armed <= 1'b0;
      end
      if (mask_wr) r_shadow <= layer_mask_in;
      r_active   <= w_active_nxt;
      r_layer_en <= {w_active_nxt[LAYER_BANNER] & (~win_flag | w_blink_nxt),
                     w_active_nxt[LAYER_SPRITE:LAYER_BG]};
    end
  end

  frame_div #(
    .DIV (BLINK_FRAMES)
  ) u_blink (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (~win_flag),
    .i_tick    (frame_start),
    .o_tgl     (w_blink),
    .o_tgl_nxt (w_blink_nxt)
  );

  assign menu_ack   = r_ack;
  assign switch_sel = r_sel;
  assign layer_en   = r_layer_en;
  assign blink_on   = w_blink;
  assign busy       = r_busy;

endmodule

// File: tb/tb_layer_ctrl.sv
// Bench for layer_ctrl: vector table, directed menu/guard/reset sequences, random run vs. frame-level model.
module tb_layer_ctrl;

  localparam int BF = 2;
  localparam int TG = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_start = 1'b0;
  logic       menu_req = 1'b0;
  logic       mask_wr = 1'b0;
  logic       win_flag = 1'b0;
  logic [3:0] layer_mask_in = 4'h0;
  logic       menu_ack, switch_sel, blink_on, busy;
  logic [3:0] layer_en;

  int checks = 0;
  int failures = 0;

  // Reference model: menu visibility, pending flag, guard frames left, frames seen while winning.
  bit         m_shown, m_pend, m_armed;
  int         m_guard, m_n;
  logic [3:0] m_shadow, m_active;
  logic       e_sel, e_ack, e_busy, e_blink;
  logic [3:0] e_en;

  typedef struct {
    bit         fs;
    bit         wr;
    bit         win;
    logic [3:0] mask;
    logic [3:0] en;
    bit         blink;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  layer_ctrl #(
    .BLINK_FRAMES (BF),
    .TOGGLE_GUARD (TG),
    .MASK_RST     (4'b0111)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .menu_req      (menu_req),
    .menu_ack      (menu_ack),
    .mask_wr       (mask_wr),
    .layer_mask_in (layer_mask_in),
    .win_flag      (win_flag),
    .switch_sel    (switch_sel),
    .layer_en      (layer_en),
    .blink_on      (blink_on),
    .busy          (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_shown = 0; m_pend = 0; m_armed = 1; m_guard = 0; m_n = 0;
    m_shadow = 4'b0111; m_active = 4'b0111;
    e_sel = 0; e_ack = 0; e_busy = 0; e_blink = 1; e_en = 4'b0111;
  endtask

  task automatic model_step();
    bit entered;
    entered = 0;
    e_ack = 0;
    if (m_pend) begin
      if (frame_start) begin
        m_shown = !m_shown;
        m_pend  = 0;
        e_ack   = 1;
      end
    end else if (menu_req && m_armed && m_guard == 0) begin
      m_pend  = 1;
      entered = 1;
    end
    if (e_ack) m_guard = TG;
    else if (frame_start && m_guard > 0) m_guard--;
    if (!menu_req) m_armed = 1;
    else if (entered) m_armed = 0;
    if (frame_start) m_active = m_shadow;
    if (mask_wr) m_shadow = layer_mask_in;
    if (!win_flag) m_n = 0;
    else if (frame_start) m_n++;
    e_blink = win_flag ? (((m_n / BF) % 2) == 0) : 1'b1;
    e_sel   = m_shown;
    e_busy  = m_pend || (m_guard > 0);
    e_en    = m_active;
    if (!e_blink) e_en[3] = 1'b0;
  endtask

  task automatic cycle(input string tag, input bit fs, input bit req, input bit wr,
                       input logic [3:0] mask, input bit win);
    frame_start = fs; menu_req = req; mask_wr = wr; layer_mask_in = mask; win_flag = win;
    model_step();
    @(posedge clk);
    #1;
    chk({tag, " sel"},   switch_sel, e_sel);
    chk({tag, " ack"},   menu_ack,   e_ack);
    chk({tag, " busy"},  busy,       e_busy);
    chk({tag, " en"},    layer_en,   e_en);
    chk({tag, " blink"}, blink_on,   e_blink);
  endtask

  task automatic do_reset(input bit check);
    frame_start = 0; menu_req = 0; mask_wr = 0; layer_mask_in = 0; win_flag = 0;
    rst_n = 0;
    #1;
    model_reset();
    if (check) begin
      chk("reset sel",   switch_sel, 0);
      chk("reset ack",   menu_ack,   0);
      chk("reset en",    layer_en,   4'b0111);
      chk("reset blink", blink_on,   1);
      chk("reset busy",  busy,       0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    int first_ack;
    bit r_req, r_win;

    tbl[0]  = '{1, 1, 0, 4'hF, 4'h7, 1};
    tbl[1]  = '{0, 0, 0, 4'h0, 4'h7, 1};
    tbl[2]  = '{1, 0, 0, 4'h0, 4'hF, 1};
    tbl[3]  = '{0, 0, 1, 4'h0, 4'hF, 1};
    tbl[4]  = '{1, 0, 1, 4'h0, 4'hF, 1};
    tbl[5]  = '{1, 0, 1, 4'h0, 4'h7, 0};
    tbl[6]  = '{1, 0, 1, 4'h0, 4'h7, 0};
    tbl[7]  = '{1, 0, 1, 4'h0, 4'hF, 1};
    tbl[8]  = '{1, 0, 1, 4'h0, 4'hF, 1};
    tbl[9]  = '{1, 0, 1, 4'h0, 4'h7, 0};
    tbl[10] = '{0, 0, 0, 4'h0, 4'hF, 1};

    #2;
    do_reset(1);

    // Mask race, then blink with half-period of two frames, then win_flag drop.
    for (int i = 0; i < 11; i++) begin
      cycle($sformatf("vec%0d", i), tbl[i].fs, 0, tbl[i].wr, tbl[i].mask, tbl[i].win);
      chk($sformatf("vec%0d tbl_en", i), layer_en, tbl[i].en);
      chk($sformatf("vec%0d tbl_blink", i), blink_on, tbl[i].blink);
    end

    // Open: request at cycle 10, frame_start at cycle 100.
    do_reset(1);
    for (int i = 1; i < 10; i++) cycle("open_idle", 0, 0, 0, 4'h0, 0);
    cycle("open_req", 0, 1, 0, 4'h0, 0);
    chk("open busy_early", busy, 1);
    for (int i = 11; i < 100; i++) cycle("open_wait", 0, 1, 0, 4'h0, 0);
    chk("open sel_before", switch_sel, 0);
    cycle("open_fs", 1, 1, 0, 4'h0, 0);
    chk("open ack_pulse", menu_ack, 1);
    chk("open sel_after", switch_sel, 1);
    cycle("open_next", 0, 1, 0, 4'h0, 0);
    chk("open ack_single", menu_ack, 0);

    // Close requested right away: guard holds it off for eight frames.
    cycle("g_drop", 0, 0, 0, 4'h0, 0);
    first_ack = 0;
    for (int k = 1; k <= 12; k++) begin
      for (int j = 0; j < 3; j++) cycle("g_idle", 0, 1, 0, 4'h0, 0);
      cycle("g_fs", 1, 1, 0, 4'h0, 0);
      if (menu_ack === 1'b1 && first_ack == 0) first_ack = k;
    end
    chk("guard ack_frame", first_ack, 9);
    chk("guard sel_closed", switch_sel, 0);

    // Reset while OPEN_PEND drops the request.
    do_reset(1);
    cycle("rp_wr", 0, 0, 1, 4'hF, 0);
    cycle("rp_fs", 1, 0, 0, 4'h0, 0);
    cycle("rp_req", 0, 1, 0, 4'h0, 0);
    chk("rp busy_pend", busy, 1);
    chk("rp en_full", layer_en, 4'hF);
    do_reset(1);
    for (int k = 0; k < 3; k++) begin
      cycle("rp_idle", 0, 0, 0, 4'h0, 0);
      cycle("rp_post_fs", 1, 0, 0, 4'h0, 0);
      chk("rp no_ack", menu_ack, 0);
      chk("rp sel_low", switch_sel, 0);
    end

    // Random traffic against the model.
    r_req = 0;
    r_win = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) r_req = !r_req;
      if ($urandom_range(0, 40) == 0) r_win = !r_win;
      cycle("rand", $urandom_range(0, 3) == 0, r_req, $urandom_range(0, 7) == 0,
            4'($urandom), r_win);
      if ($urandom_range(0, 999) == 0) do_reset(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
